// File: rtl/lru_cache_way.sv
// One way of an N-way set-associative write-back cache.
// It holds tag, valid, dirty and an LRU age for every line. It answers hits in
// the same cycle, returns read data one cycle later, and performs writes on a
// hit. A small allocation engine writes back a dirty victim and then refills
// the line. Every way sees the same access broadcasts, so the ages of all ways
// in a set stay consistent with each other.
module lru_cache_way #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int NUM_SETS        = 16,
    parameter int NUM_WAYS        = 4,
    parameter int COUNTER_WIDTH   = 8,
    parameter int WAY_INDEX       = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    input  logic [ADDRESS_WIDTH-1:0]    req_addr,
    input  logic                        req_we,
    input  logic [DATA_WIDTH-1:0]       req_wdata,
    output logic                        hit,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        rdata_valid,
    output logic [COUNTER_WIDTH-1:0]    my_age,
    output logic                        expired,
    input  logic                        access_valid,
    input  logic [$clog2(NUM_SETS)-1:0] access_set,
    input  logic [NUM_WAYS-1:0]         access_way,
    input  logic [COUNTER_WIDTH-1:0]    access_age,
    input  logic                        alloc_start,
    input  logic [ADDRESS_WIDTH-1:0]    alloc_addr,
    output logic                        wb_valid,
    output logic [ADDRESS_WIDTH-1:0]    wb_addr,
    output logic [DATA_WIDTH-1:0]       wb_data,
    input  logic                        wb_ready,
    input  logic                        fill_valid,
    input  logic [DATA_WIDTH-1:0]       fill_data,
    output logic                        fill_ready,
    output logic                        busy
);

    localparam int BYTE_W  = $clog2(DATA_WIDTH / 8);
    localparam int WORD_W  = $clog2(WORDS_PER_BLOCK);
    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = ADDRESS_WIDTH - INDEX_W - WORD_W - BYTE_W;
    localparam logic [COUNTER_WIDTH-1:0] MAX_AGE = COUNTER_WIDTH'(NUM_WAYS - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } allocState_e;

    allocState_e state;
    allocState_e stateNext;

    logic                     validArr [NUM_SETS];
    logic                     dirtyArr [NUM_SETS];
    logic [COUNTER_WIDTH-1:0] ageArr   [NUM_SETS];
    logic [TAG_W-1:0]         tagArr   [NUM_SETS];
    logic [DATA_WIDTH-1:0]    dataArr  [NUM_SETS][WORDS_PER_BLOCK];

    logic [INDEX_W-1:0] reqIdx;
    logic [WORD_W-1:0]  reqWord;
    logic [TAG_W-1:0]   reqTag;
    logic [INDEX_W-1:0] allocReqIdx;
    logic [TAG_W-1:0]   allocReqTag;

    logic [INDEX_W-1:0] allocSet;
    logic [TAG_W-1:0]   allocTag;
    logic [TAG_W-1:0]   oldTag;
    logic [WORD_W-1:0]  wordCnt;

    logic victimDirty;
    logic lastWord;
    logic wbFire;
    logic fillFire;
    logic wbDone;
    logic fillDone;
    logic enterFill;
    logic [INDEX_W-1:0] targetSet;
    logic unusedBits;

    assign reqIdx      = req_addr[BYTE_W + WORD_W +: INDEX_W];
    assign reqWord     = req_addr[BYTE_W +: WORD_W];
    assign reqTag      = req_addr[ADDRESS_WIDTH-1 -: TAG_W];
    assign allocReqIdx = alloc_addr[BYTE_W + WORD_W +: INDEX_W];
    assign allocReqTag = alloc_addr[ADDRESS_WIDTH-1 -: TAG_W];
    assign unusedBits  = ^{req_addr[BYTE_W-1:0], alloc_addr[BYTE_W+WORD_W-1:0], access_way};

    // The victim needs a writeback only if it holds modified, valid data
    assign victimDirty = validArr[allocReqIdx] & dirtyArr[allocReqIdx];
    assign lastWord    = (wordCnt == LAST_WORD);
    assign wbFire      = (state == WRITEBACK) & wb_ready;
    assign fillFire    = (state == FILL) & fill_valid;
    assign wbDone      = wbFire & lastWord;
    assign fillDone    = fillFire & lastWord;
    assign enterFill   = ((state == IDLE) & alloc_start & ~victimDirty) | wbDone;
    // The allocation set is latched on the same edge that leaves IDLE, so that edge uses the request index directly
    assign targetSet   = (state == IDLE) ? allocReqIdx : allocSet;

    // Lookup: the tag compare is combinational and is suppressed while an allocation runs
    assign hit     = req_valid & ~busy & validArr[reqIdx] & (tagArr[reqIdx] == reqTag);
    assign my_age  = ageArr[reqIdx];
    assign expired = ~validArr[reqIdx] | (ageArr[reqIdx] == MAX_AGE);

    // The writeback stream reads straight from the line. Nothing else can write it while busy, so the word holds still
    assign wb_addr = {oldTag, allocSet, wordCnt, {BYTE_W{1'b0}}};
    assign wb_data = dataArr[allocSet][wordCnt];

    // Allocation state register; reset returns to IDLE immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: dirty victims go through WRITEBACK before FILL
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (alloc_start) begin
                    stateNext = victimDirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                if (wbDone) begin
                    stateNext = FILL;
                end
            end
            FILL: begin
                if (fillDone) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Handshake outputs decode the state, so they drop as soon as reset forces IDLE
    always_comb begin
        wb_valid   = 1'b0;
        fill_ready = 1'b0;
        busy       = 1'b0;
        case (state)
            WRITEBACK: begin
                wb_valid = 1'b1;
                busy     = 1'b1;
            end
            FILL: begin
                fill_ready = 1'b1;
                busy       = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Capture the target set, the new tag and the victim's old tag when an allocation is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            allocSet <= '0;
            allocTag <= '0;
            oldTag   <= '0;
        end else if ((state == IDLE) && alloc_start) begin
            allocSet <= allocReqIdx;
            allocTag <= allocReqTag;
            oldTag   <= tagArr[allocReqIdx];
        end
    end

    // Word counter shared by writeback and fill; it wraps to zero after the last word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wordCnt <= '0;
        end else if (state == IDLE) begin
            wordCnt <= '0;
        end else if (wbFire || fillFire) begin
            wordCnt <= wordCnt + WORD_W'(1);
        end
    end

    // Line metadata. A completing fill is written last so that it overrides an access update to the same set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                validArr[s] <= 1'b0;
                dirtyArr[s] <= 1'b0;
                ageArr[s]   <= MAX_AGE;
            end
        end else begin
            if (hit && req_we) begin
                dirtyArr[reqIdx] <= 1'b1;
            end
            if (enterFill) begin
                validArr[targetSet] <= 1'b0;
            end
            if (access_valid) begin
                if (access_way[WAY_INDEX]) begin
                    ageArr[access_set] <= '0;
                end else if (validArr[access_set] && (ageArr[access_set] < access_age)
                             && (ageArr[access_set] < MAX_AGE)) begin
                    ageArr[access_set] <= ageArr[access_set] + COUNTER_WIDTH'(1);
                end
            end
            if (fillDone) begin
                validArr[allocSet] <= 1'b1;
                dirtyArr[allocSet] <= 1'b0;
                ageArr[allocSet]   <= '0;
            end
        end
    end

    // Data and tag storage, not reset. Hit writes and fill writes never overlap because hits are blocked while busy
    always_ff @(posedge clk) begin
        if (hit && req_we) begin
            dataArr[reqIdx][reqWord] <= req_wdata;
        end
        if (fillFire) begin
            dataArr[allocSet][wordCnt] <= fill_data;
        end
        if (fillDone) begin
            tagArr[allocSet] <= allocTag;
        end
    end

    // Registered read port: rdata is loaded on a hit and otherwise keeps its last value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= hit;
            if (hit) begin
                rdata <= dataArr[reqIdx][reqWord];
            end
        end
    end

endmodule
